uart_tx_ctrl: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_ctrl_if.sv | 24 ++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame layout, FSM states
// and the baud divider computation.
package uart_pkg;
  localparam int FRAME_BITS = 11;
  localparam int DATA_W     = 8;
  localparam int START_BIT  = 0;
  localparam int PAR_BIT    = 9;
  localparam int STOP_BIT   = 10;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} tx_state_e;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake and shift-register control bundle between a requester,
// the transmit controller and the external shift_reg.
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  logic                  tx_valid;
  logic [DATA_W-1:0]     tx_data;
  logic                  tx_ready;
  logic                  tx_done;
  logic                  busy;
  logic [FRAME_BITS-1:0] sr_load;
  logic                  sr_load_en;
  logic                  sr_enable;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, busy, sr_load, sr_load_en, sr_enable
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, busy, sr_load, sr_load_en, sr_enable
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Modulo-DIV bit-period counter; ticks on the last cycle of each bit period
// while running, and restarts from zero on a synchronous clear.
module uart_baud_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (run_i)
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte, assembles the 11-bit frame and
// strobes the external shift register once per bit period.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic          clk_50M,
  input  logic          reset,
  uart_tx_ctrl_if.slave tx_if
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int BCW = $clog2(FRAME_BITS + 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_ctrl: CLK_HZ/BAUD must be at least 2");
  end

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_W-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f                          = '1;
    f[START_BIT]               = 1'b0;
    f[PAR_BIT-1:START_BIT+1]   = d;
    f[PAR_BIT]                 = PARITY_EN ? ((^d) ^ PARITY_ODD) : 1'b1;
    f[STOP_BIT]                = 1'b1;
    return f;
  endfunction

  tx_state_e             state_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk_i  (clk_50M),
    .rst_i  (reset),
    .clr_i  (state_q == LOAD),
    .run_i  (state_q == SHIFT),
    .tick_o (tick)
  );

  // Frame is captured at acceptance and held until the next acceptance.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      frame_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_if.tx_valid) begin
            frame_q <= build_frame(tx_if.tx_data);
            state_q <= LOAD;
          end
        end
        LOAD: begin
          bit_cnt_q <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BCW'(FRAME_BITS - 1))
              state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_if.tx_ready   = (state_q == IDLE);
  assign tx_if.busy       = (state_q != IDLE);
  assign tx_if.tx_done    = (state_q == DONE);
  assign tx_if.sr_load_en = (state_q == LOAD);
  assign tx_if.sr_load    = frame_q;
  assign tx_if.sr_enable  = tick;
endmodule
